fmul_issue_ctrl: RTL and testbench

//  Issue/collect stage wrapped around mul_top, the fixed-latency, non-stallable FP multiplier.
//  - Accepts operand requests on a valid/ready port and drives mul_top's a/b/rnd from registers.
//  - Tracks in-flight ops with a LAT-deep valid pipe.
//  - Captures res/status into a result FIFO, presented on a valid/ready port.
//  - Keeps IEEE sticky exception flags.
//  - Credit check guarantees no mul_top result is ever dropped.

---
 rtl/fmul_pkg.sv | 18 +
 rtl/fmul_res_fifo.sv | 64 ++++++
 rtl/fmul_issue_ctrl.sv | 121 ++++++++++++
 tb/tb_fmul_issue_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fmul_pkg.sv
// Shared definitions for the FP multiplier issue/collect slice: status bit
// positions, the status type and the packed-float width helper.
package fmul_pkg;

    localparam int STATUS_W = 5;
    localparam int ST_NV    = 4;
    localparam int ST_DZ    = 3;
    localparam int ST_OF    = 2;
    localparam int ST_UF    = 1;
    localparam int ST_NX    = 0;

    typedef logic [STATUS_W-1:0] status_t;

    function automatic int flen(input int expo_w, input int mant_w);
        return 1 + expo_w + mant_w;
    endfunction

endpackage

// File: rtl/fmul_res_fifo.sv
// Synchronous result FIFO with combinational head read; pointers wrap modulo
// DEPTH and a pop while empty is ignored.
module fmul_res_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 8,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        do_pop = pop & (cnt_q != '0);
        head_d = do_pop ? ptr_inc(head_q) : head_q;
        tail_d = push ? ptr_inc(tail_q) : tail_q;
        cnt_d  = cnt_q;
        if (push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!push && do_pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage carries no reset; stale entries are never visible because the
    // read port is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_q] <= wdata;
        end
    end

    assign valid = (cnt_q != '0);
    assign rdata = valid ? mem[head_q] : '0;
    assign count = cnt_q;

endmodule

// File: rtl/fmul_issue_ctrl.sv
// Issue/collect wrapper for the fixed-latency FP multiplier: registers operands,
// tracks in-flight ops, queues results in issue order and keeps sticky flags.
module fmul_issue_ctrl
    import fmul_pkg::*;
#(
    parameter int EXPO_W     = 8,
    parameter int MANT_W     = 23,
    parameter int LAT        = 3,
    parameter int FIFO_DEPTH = 8,
    localparam int FLEN      = flen(EXPO_W, MANT_W)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FLEN-1:0] in_a,
    input  logic [FLEN-1:0] in_b,
    input  logic [1:0]      in_rnd,
    output logic [FLEN-1:0] mul_a,
    output logic [FLEN-1:0] mul_b,
    output logic [1:0]      mul_rnd,
    input  logic [FLEN-1:0] mul_res,
    input  status_t         mul_status,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FLEN-1:0] out_res,
    output status_t         out_status,
    output status_t         fflags,
    input  logic            flags_clr,
    output logic            busy
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = FLEN + STATUS_W;

    logic [FLEN-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [1:0]      mul_rnd_q, mul_rnd_d;
    logic [LAT-1:0]  vpipe_q, vpipe_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    status_t         fflags_q, fflags_d;
    logic [CW-1:0]   fifo_cnt;
    logic [CW:0]     credit_used;
    logic [EW-1:0]   fifo_rdata;
    logic            fire, capture;

    // Credit counts both in-flight ops and queued results, so every launched op
    // already owns a FIFO slot; uses registered state only.
    assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_cnt};
    assign in_ready    = credit_used < (CW + 1)'(FIFO_DEPTH);

    always_comb begin
        fire    = in_valid & in_ready;
        capture = vpipe_q[LAT-1];

        mul_a_d   = fire ? in_a   : mul_a_q;
        mul_b_d   = fire ? in_b   : mul_b_q;
        mul_rnd_d = fire ? in_rnd : mul_rnd_q;

        vpipe_d[0] = fire;
        for (int i = 1; i < LAT; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
        end

        inflight_d = inflight_q;
        if (fire && !capture) begin
            inflight_d = inflight_q + CW'(1);
        end else if (!fire && capture) begin
            inflight_d = inflight_q - CW'(1);
        end

        // A clear coinciding with a capture keeps the new event.
        fflags_d = flags_clr ? '0 : fflags_q;
        if (capture) begin
            fflags_d = fflags_d | mul_status;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            mul_rnd_q  <= '0;
            vpipe_q    <= '0;
            inflight_q <= '0;
            fflags_q   <= '0;
        end else begin
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            mul_rnd_q  <= mul_rnd_d;
            vpipe_q    <= vpipe_d;
            inflight_q <= inflight_d;
            fflags_q   <= fflags_d;
        end
    end

    fmul_res_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (capture),
        .wdata ({mul_res, mul_status}),
        .pop   (out_ready),
        .valid (out_valid),
        .rdata (fifo_rdata),
        .count (fifo_cnt)
    );

    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign mul_rnd    = mul_rnd_q;
    assign out_res    = fifo_rdata[EW-1:STATUS_W];
    assign out_status = fifo_rdata[STATUS_W-1:0];
    assign fflags     = fflags_q;
    assign busy       = (inflight_q != '0) || (fifo_cnt != '0);

    a_no_capture_when_full : assert property (
        @(posedge clk) disable iff (!rst_n) capture |-> (fifo_cnt < CW'(FIFO_DEPTH))
    );

endmodule

// File: tb/tb_fmul_issue_ctrl.sv
// Scoreboard bench for fmul_issue_ctrl with a behavioural FP32 multiplier of
// fixed latency LAT standing in for mul_top.
module tb_fmul_issue_ctrl;
    localparam int LAT   = 3;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_a = '0, in_b = '0;
    logic [1:0]  in_rnd = '0;
    logic [31:0] mul_a, mul_b, mul_res;
    logic [1:0]  mul_rnd;
    logic [4:0]  mul_status;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] out_res;
    logic [4:0]  out_status, fflags;
    logic        flags_clr = 1'b0, busy;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  st;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0, n_fail = 0;
    int   cyc = 0, n_out = 0, n_acc = 0;
    bit   chk_lat = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    fmul_issue_ctrl #(
        .EXPO_W(8), .MANT_W(23), .LAT(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_rnd(in_rnd),
        .mul_a(mul_a), .mul_b(mul_b), .mul_rnd(mul_rnd),
        .mul_res(mul_res), .mul_status(mul_status),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_status(out_status),
        .fflags(fflags), .flags_clr(flags_clr), .busy(busy)
    );

    // FP32 multiply, round-to-nearest-even, subnormals flushed to zero.
    function automatic logic [36:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s, guard, sticky;
        logic [7:0]  ea, eb;
        logic [22:0] fa, fb;
        logic [47:0] p;
        logic [23:0] m;
        int          e;
        s  = a[31] ^ b[31];
        ea = a[30:23]; eb = b[30:23];
        fa = a[22:0];  fb = b[22:0];
        if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0)) return {32'h7FC00000, 5'b00000};
        if ((ea == 8'hFF && eb == 0 && fb == 0) || (eb == 8'hFF && ea == 0 && fa == 0))
            return {32'h7FC00000, 5'b10000};
        if (ea == 8'hFF || eb == 8'hFF) return {s, 8'hFF, 23'd0, 5'b00000};
        if (ea == 0 || eb == 0) return {s, 31'd0, 5'b00000};
        p = 48'({1'b1, fa}) * 48'({1'b1, fb});
        e = int'(ea) + int'(eb) - 127;
        if (p[47]) begin
            m = {1'b0, p[46:24]}; guard = p[23]; sticky = |p[22:0]; e++;
        end else begin
            m = {1'b0, p[45:23]}; guard = p[22]; sticky = |p[21:0];
        end
        if (guard && (sticky || m[0])) m = m + 24'd1;
        if (m[23]) e++;
        if (e >= 255) return {s, 8'hFF, 23'd0, 5'b00101};
        if (e <= 0) return {s, 31'd0, 5'b00011};
        return {s, 8'(e), m[22:0], 4'b0000, guard | sticky};
    endfunction

    logic [36:0] mstage [LAT-1];
    always @(posedge clk) begin
        mstage[0] <= fp_mul(mul_a, mul_b);
        for (int i = 1; i < LAT - 1; i++) mstage[i] <= mstage[i-1];
    end
    assign {mul_res, mul_status} = mstage[LAT-2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: accepted requests push the expected result, pops are compared.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    chk("unexpected_out", 64'(out_res), 64'hDEAD);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("out  res=%h st=%b exp_res=%h exp_st=%b cyc=%0d", out_res, out_status, e.res, e.st, cyc);
                    chk("out_res", 64'(out_res), 64'(e.res));
                    chk("out_status", 64'(out_status), 64'(e.st));
                    if (chk_lat) chk("latency", 64'(cyc - e.cyc), 64'(LAT + 1));
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                {e.res, e.st} = fp_mul(in_a, in_b);
                e.cyc = cyc;
                sb.push_back(e);
                n_acc++;
                $display("in   a=%h b=%h rnd=%0d cyc=%0d", in_a, in_b, in_rnd, cyc);
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rnd);
        bit ok;
        int g = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_rnd = rnd;
        do begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1; g++;
        end while (!ok && g < 200);
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int target);
        int g = 0;
        while (n_out < target && g < 100) begin
            @(posedge clk); g++;
        end
        #1;
        chk("drain_count", 64'(n_out), 64'(target));
        chk("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, acc0, out0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fflags", 64'(fflags), 64'd0);
        chk("rst_mul_a", 64'(mul_a), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1. single op with latency and one-cycle out_valid
        chk_lat = 1'b1;
        send(32'h3F800000, 32'h40000000, 2'd0);
        chk("t1_mul_a", 64'(mul_a), 64'h3F800000);
        chk("t1_mul_b", 64'(mul_b), 64'h40000000);
        chk("t1_busy", 64'(busy), 64'd1);
        repeat (2) @(posedge clk);
        #1 chk("t1_not_yet_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1 chk("t1_valid_rise", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1 chk("t1_valid_one_cycle", 64'(out_valid), 64'd0);
        chk("t1_mul_a_hold", 64'(mul_a), 64'h3F800000);
        wait_out(1);
        chk("t1_fflags", 64'(fflags), 64'd0);

        // 2. invalid op, then a clean op leaves NV sticky
        send(32'h00000000, 32'h7F800000, 2'd0);
        wait_out(2);
        chk("t2_fflags_nv", 64'(fflags), 64'h10);
        send(32'h3F800000, 32'h3F800000, 2'd1);
        chk("t2_mul_rnd", 64'(mul_rnd), 64'd1);
        wait_out(3);
        chk("t2_fflags_sticky", 64'(fflags), 64'h10);

        // 3. backpressure: exactly DEPTH accepted, then in-order drain
        chk_lat = 1'b0;
        out_ready = 1'b0;
        acc0 = n_acc;
        out0 = n_out;
        fork
            for (int i = 0; i < 10; i++)
                send({1'b0, 8'd127, 23'(i * 32'h0001_2345)}, {1'b0, 8'd128 + 8'(i), 23'(i * 32'h0000_0F0F)}, 2'd0);
            begin
                repeat (20) @(posedge clk);
                #1 chk("t3_accepted", 64'(n_acc - acc0), 64'(DEPTH));
                for (int j = 0; j < 5; j++) begin
                    chk("t3_in_ready_low", 64'(in_ready), 64'd0);
                    @(posedge clk); #1;
                end
                chk("t3_accepted_held", 64'(n_acc - acc0), 64'(DEPTH));
                out_ready = 1'b1;
            end
        join
        wait_out(out0 + 10);

        // 4. sustained throughput
        chk_lat = 1'b1;
        out0 = n_out;
        start = cyc;
        for (int i = 0; i < 20; i++)
            send({1'b0, 8'd120 + 8'(i % 7), 23'(i * 32'h0003_1337)}, {1'b1, 8'd130, 23'(i * 32'h0000_7777)}, 2'd0);
        chk("t4_tput_cycles", 64'(cyc - start), 64'd20);
        wait_out(out0 + 20);

        // 5. flags_clr coincident with capture of an inexact op
        send(32'h3EAAAAAB, 32'h40400000, 2'd0);
        repeat (2) @(posedge clk);
        #1 flags_clr = 1'b1;
        @(posedge clk);
        #1 flags_clr = 1'b0;
        chk("t5_fflags_nx", 64'(fflags), 64'h01);
        wait_out(out0 + 21);
        chk("t5_fflags_kept", 64'(fflags), 64'h01);
        flags_clr = 1'b1;
        @(posedge clk);
        #1 flags_clr = 1'b0;
        chk("t5_clr_alone", 64'(fflags), 64'h00);

        // 6. reset with two ops in flight and one queued
        chk_lat = 1'b0;
        out_ready = 1'b0;
        send(32'h40000000, 32'h40000000, 2'd0);
        @(posedge clk); #1;
        send(32'h3F800000, 32'h00000000, 2'd0);
        send(32'h00000000, 32'h7F800000, 2'd0);
        chk("t6_busy_before", 64'(busy), 64'd1);
        chk("t6_queued", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #2;
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_fflags", 64'(fflags), 64'd0);
        chk("t6_in_ready", 64'(in_ready), 64'd1);
        chk("t6_busy", 64'(busy), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        out0 = n_out;
        repeat (12) @(posedge clk);
        #1 chk("t6_no_stale", 64'(n_out - out0), 64'd0);
        chk("t6_fflags_after", 64'(fflags), 64'd0);
        chk("t6_busy_after", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
